// File: rtl/dr_pkg.sv
// Shared rail codes, rail count and FSM state type for the dual-rail sink.
package dr_pkg;

    localparam int RAIL_NUM = 2;

    localparam logic [RAIL_NUM-1:0] DR_NULL = 2'b00;
    localparam logic [RAIL_NUM-1:0] DR_ZERO = 2'b01;
    localparam logic [RAIL_NUM-1:0] DR_ONE  = 2'b10;
    localparam logic [RAIL_NUM-1:0] DR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        HOLD      = 2'd1,
        WAIT_NULL = 2'd2
    } state_t;

endpackage

// File: rtl/dr_sink_if.sv
// Dual-rail input, acknowledge and valid/ready output bundle of dr_sink.
interface dr_sink_if #(
    parameter int WIDTH = 8
);
    import dr_pkg::*;

    logic [WIDTH-1:0][RAIL_NUM-1:0] din;
    logic                           ack;
    logic [WIDTH-1:0]               dout;
    logic                           dout_valid;
    logic                           dout_ready;
    logic                           err;

    modport master (
        output din,
        output dout_ready,
        input  ack,
        input  dout,
        input  dout_valid,
        input  err
    );

    modport slave (
        input  din,
        input  dout_ready,
        output ack,
        output dout,
        output dout_valid,
        output err
    );

endinterface

// File: rtl/dr_sync.sv
// SYNC_STAGES-deep flop chain bringing one asynchronous rail into the clk domain (SYNC_STAGES >= 2).
module dr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dr_sink.sv
// Dual-rail to single-rail receiver: synchronise, filter completion, decode, acknowledge.
// Define DR_SINK_ERR_EN to enable the sticky illegal-code flag on err.
module dr_sink
    import dr_pkg::*;
#(
    parameter string ENC         = "TP",
    parameter int    WIDTH       = 8,
    parameter int    SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    dr_sink_if.slave   bus
);

    localparam bit IS_FP = (ENC == "FP");

    // NOTE: reset asserts asynchronously but releases through two flops so no flop sees a late removal.
    logic rst_meta_q;
    logic rst_int_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q  <= 1'b0;
            rst_int_n_q <= 1'b0;
        end else begin
            rst_meta_q  <= 1'b1;
            rst_int_n_q <= rst_meta_q;
        end
    end

    logic [WIDTH-1:0][RAIL_NUM-1:0] s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        for (genvar r = 0; r < RAIL_NUM; r++) begin : g_rail
            dr_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_int_n_q),
                .d_i   (bus.din[i][r]),
                .q_o   (s[i][r])
            );
        end
    end

    // ref_q stays zero in FP, so the same XOR view serves both encodings.
    logic [WIDTH-1:0][RAIL_NUM-1:0] ref_q;
    logic [WIDTH-1:0][RAIL_NUM-1:0] cap_q;
    logic [WIDTH-1:0][RAIL_NUM-1:0] s_prev_q;
    logic [WIDTH-1:0][RAIL_NUM-1:0] cmp;
    logic [WIDTH-1:0]               bit_done;
    logic [WIDTH-1:0]               bit_ill;
    logic [WIDTH-1:0]               dec;
    logic                           complete;
    logic                           complete_q;
    logic                           stable;
    logic                           all_null;
    logic                           null_q;

    always_comb begin
        cmp      = s ^ ref_q;
        bit_done = '0;
        bit_ill  = '0;
        dec      = '0;
        all_null = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            bit_done[i] = (cmp[i] == DR_ZERO) || (cmp[i] == DR_ONE);
            bit_ill[i]  = (cmp[i] == DR_ILL);
            dec[i]      = (cmp[i] == DR_ONE);
            if (s[i] != DR_NULL) begin
                all_null = 1'b0;
            end
        end
        complete = (&bit_done) && !(|bit_ill);
        stable   = complete && complete_q && (s == s_prev_q);
    end

    always_ff @(posedge clk or negedge rst_int_n_q) begin
        if (!rst_int_n_q) begin
            s_prev_q   <= '0;
            complete_q <= 1'b0;
            null_q     <= 1'b0;
        end else begin
            s_prev_q   <= s;
            complete_q <= complete;
            null_q     <= all_null;
        end
    end

`ifdef DR_SINK_ERR_EN
    logic ill_q;
    logic err_q;

    always_ff @(posedge clk or negedge rst_int_n_q) begin
        if (!rst_int_n_q) begin
            ill_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ill_q <= |bit_ill;
            err_q <= err_q | ((|bit_ill) && ill_q);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             ack_q;

    always_ff @(posedge clk or negedge rst_int_n_q) begin
        if (!rst_int_n_q) begin
            state_q <= WAIT_DATA;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            ref_q   <= '0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                WAIT_DATA: begin
                    if (stable) begin
                        dout_q  <= dec;
                        cap_q   <= s;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.dout_ready) begin
                        valid_q <= 1'b0;
                        if (IS_FP) begin
                            ack_q   <= 1'b1;
                            state_q <= WAIT_NULL;
                        end else begin
                            ack_q   <= ~ack_q;
                            ref_q   <= cap_q;
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_NULL: begin
                    if (all_null && null_q) begin
                        ack_q   <= 1'b0;
                        state_q <= WAIT_DATA;
                    end
                end
                default: state_q <= WAIT_DATA;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;

endmodule
